// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared types and constants for the Hack ROM loader
package hack_pkg;

  localparam int HACK_ROM_ADDR_W = 15;
  localparam int HACK_WORD_W     = 16;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    RUN     = 3'd4,
    ERROR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/rom_array.sv
// rtl/rom_array.sv - instruction store, one synchronous write port, one asynchronous read port
module rom_array #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset: contents survive reload and reset_n so unwritten words keep old values.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - boot loader that fills the Hack instruction ROM and gates CPU reset
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W = HACK_ROM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic                   reload,
  input  logic [ADDR_W-1:0]      pc,
  output logic [HACK_WORD_W-1:0] instruction,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_W:0]        word_count
);

  localparam int          CW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  loader_state_t          state;
  logic [7:0]             hi_byte;
  logic [ADDR_W-1:0]      wr_addr;
  logic [CW-1:0]          n_words;
  logic                   accept;
  logic [15:0]            len_word;
  logic [CW-1:0]          wc_next;
  logic                   rom_we;
  logic [HACK_WORD_W-1:0] rom_rdata;

  assign accept   = rx_valid && rx_ready;
  // hi_byte holds LEN_HI during the length phase and the data high byte afterwards.
  assign len_word = {hi_byte, rx_data};
  assign wc_next  = word_count + CW'(1);
  assign rom_we   = accept && (state == DATA_LO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LEN_HI;
      hi_byte    <= '0;
      wr_addr    <= '0;
      word_count <= '0;
      n_words    <= '0;
    end else begin
      case (state)
        LEN_HI: begin
          if (accept) begin
            hi_byte <= rx_data;
            state   <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            if (len_word == 16'd0) begin
              state <= RUN;
            end else if (32'(len_word) > DEPTH) begin
              state <= ERROR;
            end else begin
              n_words <= CW'(len_word);
              state   <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_byte <= rx_data;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            // A full-depth load wraps wr_addr to 0 on the same edge that enters RUN.
            wr_addr    <= wr_addr + ADDR_W'(1);
            word_count <= wc_next;
            state      <= (wc_next == n_words) ? RUN : DATA_HI;
          end
        end
        RUN, ERROR: begin
          if (reload) begin
            state      <= LEN_HI;
            wr_addr    <= '0;
            word_count <= '0;
          end
        end
        default: state <= LEN_HI;
      endcase
    end
  end

  rom_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (HACK_WORD_W)
  ) u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (wr_addr),
    .wdata ({hi_byte, rx_data}),
    .raddr (pc),
    .rdata (rom_rdata)
  );

  assign rx_ready    = (state == LEN_HI) || (state == LEN_LO) ||
                       (state == DATA_HI) || (state == DATA_LO);
  assign cpu_reset   = (state != RUN);
  assign done        = (state == RUN);
  assign error       = (state == ERROR);
  assign instruction = (state == RUN) ? rom_rdata : '0;

endmodule

// File: tb/tb_hack_rom_loader.sv
// tb/tb_hack_rom_loader.sv - table-driven bench for hack_rom_loader
module tb_hack_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic [14:0] pc;
  logic [15:0] instruction;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;

  hack_rom_loader #(.ADDR_W(15)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .reload      (reload),
    .pc          (pc),
    .instruction (instruction),
    .cpu_reset   (cpu_reset),
    .done        (done),
    .error       (error),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        rel;
    logic [14:0] pc;
    logic        rdy;
    logic        crst;
    logic        dn;
    logic        err;
    logic [15:0] wc;
    logic [15:0] instr;
  } vec_t;

  vec_t vecs[$];
  int   vec_no = 0;

  function automatic vec_t mk(logic [7:0] d, logic v, logic r, logic [14:0] p,
                              logic rdy, logic crst, logic dn, logic err,
                              logic [15:0] wc, logic [15:0] ins);
    vec_t t;
    t.data = d; t.valid = v; t.rel = r; t.pc = p;
    t.rdy = rdy; t.crst = crst; t.dn = dn; t.err = err; t.wc = wc; t.instr = ins;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Loading-state outputs with the given word count.
  function automatic vec_t ld(logic [7:0] d, logic v, logic [15:0] wc);
    return mk(d, v, 1'b0, 15'd0, 1'b1, 1'b1, 1'b0, 1'b0, wc, 16'h0000);
  endfunction

  // RUN-state outputs.
  function automatic vec_t rn(logic r, logic [14:0] p, logic [15:0] wc, logic [15:0] ins);
    return mk(8'h55, 1'b1, r, p, 1'b0, 1'b0, 1'b1, 1'b0, wc, ins);
  endfunction

  task automatic run_vecs();
    foreach (vecs[i]) begin
      rx_data  = vecs[i].data;
      rx_valid = vecs[i].valid;
      reload   = vecs[i].rel;
      pc       = vecs[i].pc;
      #1;
      chk("rx_ready",    vec_no, 32'(rx_ready),    32'(vecs[i].rdy));
      chk("cpu_reset",   vec_no, 32'(cpu_reset),   32'(vecs[i].crst));
      chk("done",        vec_no, 32'(done),        32'(vecs[i].dn));
      chk("error",       vec_no, 32'(error),       32'(vecs[i].err));
      chk("word_count",  vec_no, 32'(word_count),  32'(vecs[i].wc));
      chk("instruction", vec_no, 32'(instruction), 32'(vecs[i].instr));
      vec_no++;
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reload   = 1'b0;
    pc       = 15'd0;
    #1;
    chk("reset rx_ready",    -1, 32'(rx_ready),    32'd1);
    chk("reset cpu_reset",   -1, 32'(cpu_reset),   32'd1);
    chk("reset done",        -1, 32'(done),        32'd0);
    chk("reset error",       -1, 32'(error),       32'd0);
    chk("reset word_count",  -1, 32'(word_count),  32'd0);
    chk("reset instruction", -1, 32'(instruction), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Back-to-back 2-word load
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(ld(8'h02, 1'b1, 16'd0));
    vecs.push_back(ld(8'hEC, 1'b1, 16'd0));
    vecs.push_back(ld(8'h10, 1'b1, 16'd0));
    vecs.push_back(ld(8'hE3, 1'b1, 16'd1));
    vecs.push_back(ld(8'h08, 1'b1, 16'd1));
    vecs.push_back(rn(1'b0, 15'd1, 16'd2, 16'hE308));
    vecs.push_back(rn(1'b0, 15'd0, 16'd2, 16'hEC10));
    // Reload, then same stream with rx_valid toggling
    vecs.push_back(rn(1'b1, 15'd0, 16'd2, 16'hEC10));
    vecs.push_back(ld(8'h00, 1'b0, 16'd0));
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(ld(8'h02, 1'b0, 16'd0));
    vecs.push_back(ld(8'h02, 1'b1, 16'd0));
    vecs.push_back(ld(8'hEC, 1'b0, 16'd0));
    vecs.push_back(ld(8'hEC, 1'b1, 16'd0));
    vecs.push_back(ld(8'h10, 1'b0, 16'd0));
    vecs.push_back(ld(8'h10, 1'b1, 16'd0));
    vecs.push_back(ld(8'hE3, 1'b0, 16'd1));
    vecs.push_back(ld(8'hE3, 1'b1, 16'd1));
    vecs.push_back(ld(8'h08, 1'b0, 16'd1));
    vecs.push_back(ld(8'h08, 1'b1, 16'd1));
    vecs.push_back(rn(1'b0, 15'd1, 16'd2, 16'hE308));
    vecs.push_back(rn(1'b0, 15'd0, 16'd2, 16'hEC10));
    // Oversize length 0x8001 -> ERROR, bytes not consumed, reload recovers
    vecs.push_back(rn(1'b1, 15'd0, 16'd2, 16'hEC10));
    vecs.push_back(ld(8'h80, 1'b1, 16'd0));
    vecs.push_back(ld(8'h01, 1'b1, 16'd0));
    vecs.push_back(mk(8'h00, 1'b1, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 16'h0000));
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 15'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 16'h0000));
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(ld(8'h01, 1'b1, 16'd0));
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(ld(8'h07, 1'b1, 16'd0));
    vecs.push_back(rn(1'b0, 15'd0, 16'd1, 16'h0007));
    vecs.push_back(rn(1'b0, 15'd1, 16'd1, 16'hE308));
    // Zero-length load keeps old ROM contents
    vecs.push_back(rn(1'b1, 15'd0, 16'd1, 16'h0007));
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(rn(1'b0, 15'd1, 16'd0, 16'hE308));
    // Reload from RUN with a 1-word load; ROM[1] retained
    vecs.push_back(rn(1'b1, 15'd0, 16'd0, 16'h0007));
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(ld(8'h01, 1'b1, 16'd0));
    vecs.push_back(ld(8'h12, 1'b1, 16'd0));
    vecs.push_back(ld(8'h34, 1'b1, 16'd0));
    vecs.push_back(rn(1'b0, 15'd0, 16'd1, 16'h1234));
    vecs.push_back(rn(1'b0, 15'd1, 16'd1, 16'hE308));
    // Length 0x8000 is the full depth and must not error
    vecs.push_back(rn(1'b1, 15'd0, 16'd1, 16'h1234));
    vecs.push_back(ld(8'h80, 1'b1, 16'd0));
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(ld(8'hAA, 1'b0, 16'd0));
    run_vecs();

    reset_n = 1'b0;
    #1;
    chk("async rst rx_ready",  -2, 32'(rx_ready),  32'd1);
    chk("async rst cpu_reset", -2, 32'(cpu_reset), 32'd1);
    #1;
    reset_n = 1'b1;

    // Partial 2-word load: one word written, mid second word
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(ld(8'h02, 1'b1, 16'd0));
    vecs.push_back(ld(8'h11, 1'b1, 16'd0));
    vecs.push_back(ld(8'h22, 1'b1, 16'd0));
    vecs.push_back(ld(8'h33, 1'b1, 16'd1));
    run_vecs();

    rx_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("mid-load rst word_count", -3, 32'(word_count), 32'd0);
    chk("mid-load rst rx_ready",   -3, 32'(rx_ready),   32'd1);
    chk("mid-load rst cpu_reset",  -3, 32'(cpu_reset),  32'd1);
    #1;
    reset_n = 1'b1;

    // Fresh load restarts at address 0
    vecs.push_back(ld(8'h00, 1'b1, 16'd0));
    vecs.push_back(ld(8'h01, 1'b1, 16'd0));
    vecs.push_back(ld(8'hAB, 1'b1, 16'd0));
    vecs.push_back(ld(8'hCD, 1'b1, 16'd0));
    vecs.push_back(rn(1'b0, 15'd0, 16'd1, 16'hABCD));
    vecs.push_back(rn(1'b0, 15'd1, 16'd1, 16'hE308));
    run_vecs();

    pc      = 15'd0;
    reset_n = 1'b0;
    #1;
    chk("run rst cpu_reset",   -4, 32'(cpu_reset),   32'd1);
    chk("run rst done",        -4, 32'(done),        32'd0);
    chk("run rst instruction", -4, 32'(instruction), 32'd0);
    chk("run rst rx_ready",    -4, 32'(rx_ready),    32'd1);
    chk("run rst word_count",  -4, 32'(word_count),  32'd0);
    #1;
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Boot-time program loader and instruction store for the Hack CPU. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit words into the instruction ROM and holds the CPU in reset until the load completes. It then serves `instruction = ROM[pc]` combinationally to the CPU fetch path. It sits directly upstream of the CPU's `instruction` input and drives the CPU's `reset`.

## Interface
- `ADDR_W`, 15: ROM address width; depth = 2^ADDR_W words (32K for the full Hack map).
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  loader byte stream.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte. A byte transfers on a rising edge with `rx_valid && rx_ready`.
- `reload`  in  1  single-cycle request to restart loading. Honoured only in RUN and ERROR.
- `pc`  in  ADDR_W  CPU program counter.
- `instruction`  out  16  `ROM[pc]` in RUN, otherwise 16'h0000.
- `cpu_reset`  out  1  active-high reset to the CPU. High in every state except RUN.
- `done`  out  1  high in RUN.
- `error`  out  1  high in ERROR.
- `word_count`  out  ADDR_W+1  number of words written in the current load.

## Operation
- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words, each sent as high byte then low byte.
- FSM states: LEN_HI → LEN_LO → {DATA_HI ↔ DATA_LO} → RUN, plus ERROR.
  - LEN_LO accept:
    - {hi,lo} == 0: go to RUN.
    - {hi,lo} > 2^ADDR_W: go to ERROR.
    - otherwise: latch N and go to DATA_HI.
  - DATA_HI accept: latch the high byte and go to DATA_LO.
  - DATA_LO accept: write ROM[wr_addr] <= {hi_byte, rx_data}, increment `wr_addr` and `word_count`. If `word_count`+1 == N, go to RUN; otherwise go to DATA_HI.
  - RUN and ERROR are left only by `reload` (to LEN_HI, with `wr_addr` and `word_count` cleared) or by `reset_n`.
- `rx_ready` = 1 in LEN_HI, LEN_LO, DATA_HI and DATA_LO; 0 in RUN and ERROR. Bytes presented while `rx_ready` = 0 are not consumed.
- ROM words above N keep their previous contents; they are not cleared on reload or reset.
- `reload` arriving in a loading state has no effect.

## Timing
- Reset values:
  - state = LEN_HI, `rx_ready` = 1, `cpu_reset` = 1, `done` = 0, `error` = 0, `word_count` = 0, `instruction` = 0.
- Each accepted byte advances the FSM on the same edge. There are no stall cycles, so one byte per clock is sustained.
- Completion: the edge that accepts the final low byte both writes the ROM and enters RUN. From the next cycle `cpu_reset` = 0, `done` = 1 and `rx_ready` = 0. The CPU's first fetch therefore sees ROM[0] freshly written.
- Zero-length load: the edge accepting LEN_LO enters RUN.
- `instruction` is a combinational read of `pc` with zero latency, gated to 0 when not in RUN.
- `reload` in RUN: on the next edge, state = LEN_HI, `cpu_reset` = 1, `done` = 0.
- `reset_n` low mid-load: outputs return to their reset values immediately (asynchronously). The partial ROM contents remain, and the next load restarts at address 0.
- Full depth N = 2^ADDR_W is legal: `wr_addr` wraps to 0 exactly as the FSM enters RUN, and `word_count` = 2^ADDR_W.

## Structure
- Shared package `hack_pkg`:
  - `loader_state_t` enum (LEN_HI, LEN_LO, DATA_HI, DATA_LO, RUN, ERROR).
  - Constant `HACK_ROM_ADDR_W` = 15.
  - Constant `HACK_WORD_W` = 16.
- One sub-module, `rom_array`: single write port (clk, we, waddr, wdata) and one asynchronous read port (raddr, rdata). It has no reset.
- FSM, byte assembly, counters and output gating live in `hack_rom_loader`.

## Test plan
- Reset, then stream 00 02 | EC 10 | E3 08 → ROM[0] = 16'hEC10, ROM[1] = 16'hE308. `cpu_reset` falls the cycle after the last accept. With `pc` = 1, `instruction` = 16'hE308.
- Same stream with `rx_valid` toggled every other cycle → identical ROM contents. No byte is consumed while `rx_valid` = 0, and `word_count` steps 0→1→2.
- Length 00 00 → RUN one cycle after the LEN_LO accept, `word_count` = 0, `instruction` = old ROM[pc].
- Length 80 01 with ADDR_W = 15 → `error` = 1, `rx_ready` = 0, `cpu_reset` stays 1. Then `reload` followed by a valid 00 01 | 00 07 load → RUN with ROM[0] = 16'h0007.
- `reset_n` pulsed low after 3 bytes of a 2-word load → `cpu_reset` = 1 and `rx_ready` = 1 asynchronously. A fresh 00 01 | AB CD load writes ROM[0] = 16'hABCD.
- In RUN, pulse `reload` and present bytes 00 01 | 12 34 → `cpu_reset` is high during the load, ROM[0] = 16'h1234, and ROM[1] retains its previous value.
